// File: rtl/sub_seq_pkg.sv
// rtl/sub_seq_pkg.sv - shared types and sizing helpers for the serial subtract sequencer
package sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 2;

    // Step counter width: ceil(log2(N)) with a floor of one bit.
    function automatic int cnt_width(input int width);
        int n;
        n = width / SLICE_W;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub2_slice.sv
// rtl/sub2_slice.sv - combinational 2-bit borrow-ripple subtractor slice
module sub2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       bin,
    output logic [1:0] d,
    output logic       bout
);

    logic b_mid;

    always_comb begin
        d[0]  = x[0] ^ y[0] ^ bin;
        b_mid = (~x[0] & y[0]) | (~x[0] & bin) | (y[0] & bin);
        d[1]  = x[1] ^ y[1] ^ b_mid;
        bout  = (~x[1] & y[1]) | (~x[1] & b_mid) | (y[1] & b_mid);
    end

endmodule

// File: rtl/serial_subtract_sequencer.sv
// rtl/serial_subtract_sequencer.sv - two-bits-per-clock subtractor sequencer; optional SUB_SIGNED_OVF_EN adds ovf
module serial_subtract_sequencer
    import sub_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
`ifdef SUB_SIGNED_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic [1:0]         s_d;
    logic               s_bout;
    logic [WIDTH-1:0]   part_shift;

    sub2_slice u_slice (
        .x    (a_sh_q[1:0]),
        .y    (b_sh_q[1:0]),
        .bin  (borrow_q),
        .d    (s_d),
        .bout (s_bout)
    );

    // New slice bits enter at the MSB so the LSB slice ends up at bit 0 after N steps.
    assign part_shift = WIDTH'({s_d, part_q} >> SLICE_W);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = b_in;
                    cnt_d    = '0;
                    part_d   = '0;
`ifdef SUB_SIGNED_OVF_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> SLICE_W;
                b_sh_d   = b_sh_q >> SLICE_W;
                borrow_d = s_bout;
                part_d   = part_shift;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    diff_d  = part_shift;
                    bout_d  = s_bout;
`ifdef SUB_SIGNED_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (part_shift[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtract_sequencer.sv
// tb/tb_serial_subtract_sequencer.sv - scoreboard bench for WIDTH=8 and WIDTH=2 instances
module tb_serial_subtract_sequencer;

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       bin8, bin2;
    logic       busy8, done8, bout8;
    logic       busy2, done2, bout2;
    logic [7:0] diff8;
    logic [1:0] diff2;
`ifdef SUB_SIGNED_OVF_EN
    logic       ovf8, ovf2;
`endif

    int checks = 0;
    int errors = 0;
    exp_t q8[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    serial_subtract_sequencer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .b_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8)
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtract_sequencer #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .b_in(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bout2)
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovf2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic done on plain integers.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        int   full;
        int   mask;
        mask   = (1 << w) - 1;
        full   = int'(a) - int'(b) - int'(bin);
        e.diff = 8'(full & mask);
        e.bout = (full < 0);
        e.ovf  = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                exp_t e;
                e = q8.pop_front();
                chk("diff8", diff8, e.diff);
                chk("borrow8", bout8, e.bout);
                chk("done_busy8", busy8, 0);
`ifdef SUB_SIGNED_OVF_EN
                chk("ovf8", ovf8, e.ovf);
`endif
            end
        end
        if (rst_n === 1'b1 && done2 === 1'b1) begin
            if (q2.size() == 0) chk("unexpected_done2", 1, 0);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("diff2", diff2, e.diff);
                chk("borrow2", bout2, e.bout);
`ifdef SUB_SIGNED_OVF_EN
                chk("ovf2", ovf2, e.ovf);
`endif
            end
        end
    end

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int   cyc;
        exp_t e;
        e = model(8, a, b, bin);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_after_accept8", busy8, 1);
        wait_done8(cyc);
        chk("latency8", cyc, 4);
        @(negedge clk);
        chk("done_pulse8", done8, 0);
        chk("diff_hold8", diff8, e.diff);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bin);
        int cyc;
        @(negedge clk);
        a2 = a; b2 = b; bin2 = bin; start2 = 1'b1;
        q2.push_back(model(2, {6'd0, a}, {6'd0, b}, bin));
        @(negedge clk);
        start2 = 1'b0;
        chk("busy_after_accept2", busy2, 1);
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency2", cyc, 1);
    endtask

    initial begin
        int   cyc;
        int   seen;
        exp_t e;

        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", bout8, 0);
`ifdef SUB_SIGNED_OVF_EN
        chk("rst_ovf", ovf8, 0);
`endif
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        op8(8'h10, 8'h0F, 1'b1);
        op8(8'hA3, 8'h5C, 1'b1);

        // Start pulses during RUN and DONE must be ignored.
        e = model(8, 8'h37, 8'h12, 1'b0);
        @(negedge clk);
        a8 = 8'h37; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(cyc);
        chk("ignore_run_latency", cyc, 2);
        a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("ignore_done_busy", busy8, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy8 || done8) seen++;
        end
        chk("ignore_no_restart", seen, 0);
        chk("ignore_diff_kept", diff8, e.diff);

        // Reset on the second RUN cycle aborts the operation.
        @(negedge clk);
        a8 = 8'h44; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back(model(8, 8'h44, 8'h11, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        chk("busy_before_abort", busy8, 1);
        rst_n = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_borrow", bout8, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        chk("abort_no_done", seen, 0);
        op8(8'h44, 8'h11, 1'b0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        start8 = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        start8 = 1'b0; rst_n = 1'b1;
        chk("rst_beats_start", busy8, 0);
        @(negedge clk);
        chk("rst_beats_start_next", busy8, 0);

        op8(8'h80, 8'h01, 1'b0);
        op8(8'h7F, 8'hFF, 1'b0);

        for (int i = 0; i < 32; i++) begin
            op2(2'(i >> 3), 2'(i >> 1), i[0]);
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
